// File: rtl/ucaspian_step_ctrl.sv
// ucaspian_step_ctrl: sequences STEP commands (pulse / guard / wait for idle)
// and CLEAR sweeps for the uCaspian core, reporting completion on rsp_*.
// Optional 10-bit watchdog on WAIT/CLEAR when UCASPIAN_STEP_TIMEOUT_EN is defined.
module ucaspian_step_ctrl #(
  parameter int unsigned STEP_GUARD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_count,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  output logic        next_step,
  input  logic        step_done,
  output logic        clear_act,
  output logic        clear_config,
  input  logic        clear_done,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [15:0] rsp_time,
  output logic        rsp_err,
  output logic [15:0] cur_time,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PULSE, GUARD, WAIT, CLEAR, RELEASE, RESP} state_t;
  typedef enum logic [1:0] {OP_STEP, OP_CLEAR_ACT, OP_CLEAR_CONFIG, OP_RSVD} op_t;

  state_t      state, state_d;
  op_t         op_q, op_d;
  logic [7:0]  remain, remain_d;
  logic [7:0]  guard, guard_d;
  logic [15:0] time_d, rsp_time_d;
  logic        err_d;
  logic        cmd_rdy_d, busy_d, next_step_d, clear_act_d, clear_config_d, rsp_vld_d;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
  logic [9:0]  wd, wd_d;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    op_d     = op_q;
    remain_d = remain;
    guard_d  = guard;
    time_d   = cur_time;
    err_d    = rsp_err;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
    wd_d     = wd;
`endif
    case (state)
      IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          op_d = op_t'(cmd_op);
          case (op_t'(cmd_op))
            OP_STEP: begin
              if (cmd_count == '0) begin
                state_d = RESP;
                err_d   = 1'b0;
              end else begin
                remain_d = cmd_count;
                state_d  = PULSE;
              end
            end
            OP_CLEAR_ACT, OP_CLEAR_CONFIG: begin
              state_d = CLEAR;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
              wd_d    = '0;
`endif
            end
            OP_RSVD: begin
              state_d = RESP;
              err_d   = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      PULSE: begin
        state_d = GUARD;
        guard_d = 8'(STEP_GUARD);
      end
      // step_done is not looked at here: it still carries the stale idle level
      GUARD: begin
        if (guard == '0) begin
          state_d = WAIT;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          guard_d = guard - 8'd1;
        end
      end
      WAIT: begin
        if (step_done) begin
          time_d   = cur_time + 16'd1;
          remain_d = remain - 8'd1;
          if (remain > 8'd1) begin
            state_d = PULSE;
          end else begin
            state_d = RESP;
            err_d   = 1'b0;
          end
        end
`ifdef UCASPIAN_STEP_TIMEOUT_EN
        // wd is 0 in the first WAIT cycle, so abort leaves after 1023 cycles
        else if (wd == 10'd1022) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          wd_d = wd + 10'd1;
        end
`endif
      end
      CLEAR: begin
        if (clear_done) begin
          time_d  = '0;
          state_d = RELEASE;
        end
`ifdef UCASPIAN_STEP_TIMEOUT_EN
        else if (wd == 10'd1022) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          wd_d = wd + 10'd1;
        end
`endif
      end
      RELEASE: begin
        if (!clear_done) begin
          state_d = RESP;
          err_d   = 1'b0;
        end
      end
      RESP: begin
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output is registered
  always_comb begin
    cmd_rdy_d      = (state_d == IDLE);
    busy_d         = (state_d != IDLE);
    next_step_d    = (state_d == PULSE);
    clear_act_d    = (state_d == CLEAR);
    clear_config_d = (state_d == CLEAR) && (op_d == OP_CLEAR_CONFIG);
    rsp_vld_d      = (state_d == RESP);
    rsp_time_d     = rsp_time;
    if (state_d == RESP && state != RESP) rsp_time_d = time_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q         <= OP_STEP;
      remain       <= '0;
      guard        <= '0;
      cur_time     <= '0;
      rsp_time     <= '0;
      rsp_err      <= 1'b0;
      cmd_rdy      <= 1'b0;
      busy         <= 1'b0;
      next_step    <= 1'b0;
      clear_act    <= 1'b0;
      clear_config <= 1'b0;
      rsp_vld      <= 1'b0;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
      wd           <= '0;
`endif
    end else begin
      op_q         <= op_d;
      remain       <= remain_d;
      guard        <= guard_d;
      cur_time     <= time_d;
      rsp_time     <= rsp_time_d;
      rsp_err      <= err_d;
      cmd_rdy      <= cmd_rdy_d;
      busy         <= busy_d;
      next_step    <= next_step_d;
      clear_act    <= clear_act_d;
      clear_config <= clear_config_d;
      rsp_vld      <= rsp_vld_d;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
      wd           <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Scoreboard bench for ucaspian_step_ctrl: stimulus pushes expected responses,
// a monitor pops them on each rsp handshake.
module tb_ucaspian_step_ctrl;
  localparam int unsigned GUARD = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_count;
  logic        cmd_vld, cmd_rdy, next_step, step_done;
  logic        clear_act, clear_config, clear_done;
  logic        rsp_vld, rsp_rdy, rsp_err, busy;
  logic [15:0] rsp_time, cur_time;

  typedef struct packed {
    logic [15:0] t;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          npulse = 0;
  int          last_pulse = -1;
  int          sd_mode = 0;
  logic [15:0] exp_time = '0;

  ucaspian_step_ctrl #(.STEP_GUARD(GUARD)) dut (
    .clk(clk), .reset(reset),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .next_step(next_step), .step_done(step_done),
    .clear_act(clear_act), .clear_config(clear_config), .clear_done(clear_done),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_time(rsp_time), .rsp_err(rsp_err),
    .cur_time(cur_time), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] t, input logic e);
    exp_t x;
    x.t   = t;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // Unit model: mode 0 = stale high, low, rise 4 cycles after pulse; 1 = held 1; 2 = stuck 0
  initial begin
    int k;
    k = 0;
    step_done = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (sd_mode == 1) step_done = 1'b1;
      else if (sd_mode == 2) step_done = 1'b0;
      else if (next_step) k = 1;
      else if (k != 0) begin
        step_done = (k == 1) || (k == 4);
        k = (k == 4) ? 0 : k + 1;
      end
    end
  end

  // Response monitor: pops the scoreboard on every handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_time", 32'(rsp_time), 32'(e.t));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Pulse monitor: spacing and exclusivity with clear requests
  initial forever begin
    @(negedge clk);
    if (reset && next_step) begin
      chk("pulse_excl", 32'(clear_act || clear_config), 0);
      if (last_pulse >= 0) chk("pulse_gap", 32'((cyc - last_pulse) >= int'(GUARD + 1)), 1);
      last_pulse = cyc;
      npulse++;
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] cnt);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_op = op; cmd_count = cnt; cmd_vld = 1'b1;
    @(negedge clk);
    while (!cmd_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_rdy), 1);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_budget", 32'(busy), 0);
  endtask

  task automatic do_step(input logic [7:0] n);
    int p0;
    p0 = npulse;
    last_pulse = -1;
    exp_time = exp_time + 16'(n);
    push_exp(exp_time, 1'b0);
    send(2'd0, n);
    wait_idle(4000);
    chk("pulse_count", 32'(npulse - p0), 32'(n));
  endtask

  task automatic wait_clear_drop();
    int n;
    n = 0;
    @(negedge clk);
    while (clear_act && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("clear_drop", 32'(clear_act), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_next_step"}, 32'(next_step), 0);
    chk({tag, "_clear_act"}, 32'(clear_act), 0);
    chk({tag, "_clear_config"}, 32'(clear_config), 0);
    chk({tag, "_rsp_vld"}, 32'(rsp_vld), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_rsp_time"}, 32'(rsp_time), 0);
    chk({tag, "_cur_time"}, 32'(cur_time), 0);
    chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk("cmd_rdy_before_clock", 32'(cmd_rdy), 0);
    @(negedge clk);
    chk("cmd_rdy_first_clock", 32'(cmd_rdy), 1);
  endtask

  initial begin
    int p0;
    int n;
    reset = 1'b0; cmd_op = '0; cmd_count = '0; cmd_vld = 1'b0;
    clear_done = 1'b0; rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    release_reset();

    // Three steps, units answer 4 cycles after each pulse
    sd_mode = 0;
    do_step(8'd3);

    // One step with step_done held high: guard must hold off completion
    sd_mode = 1;
    p0 = npulse;
    last_pulse = -1;
    exp_time = exp_time + 16'd1;
    push_exp(exp_time, 1'b0);
    send(2'd0, 8'd1);
    n = 0;
    @(negedge clk);
    while (!rsp_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("held_rsp_vld", 32'(rsp_vld), 1);
    chk("guard_latency", 32'((cyc - last_pulse) >= int'(GUARD + 1)), 1);
    wait_idle(100);
    chk("held_pulse_count", 32'(npulse - p0), 1);

    // Zero-count step and reserved op
    p0 = npulse;
    push_exp(exp_time, 1'b0);
    send(2'd0, 8'd0);
    wait_idle(100);
    chk("zero_count_pulses", 32'(npulse - p0), 0);
    push_exp(exp_time, 1'b1);
    send(2'd3, 8'd7);
    wait_idle(100);

    // Response back-pressure with a competing command
    rsp_rdy = 1'b0;
    exp_time = exp_time + 16'd2;
    push_exp(exp_time, 1'b0);
    send(2'd0, 8'd2);
    n = 0;
    @(negedge clk);
    while (!rsp_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    cmd_op = 2'd0; cmd_count = 8'd5; cmd_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_rsp_vld", 32'(rsp_vld), 1);
      chk("stall_rsp_time", 32'(rsp_time), 32'(exp_time));
      chk("stall_cmd_rdy", 32'(cmd_rdy), 0);
    end
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    cmd_vld = 1'b0;
    p0 = npulse;
    wait_idle(100);
    repeat (10) @(negedge clk);
    chk("stall_cmd_not_consumed", 32'(npulse - p0), 0);
    chk("stall_busy", 32'(busy), 0);

    // Five steps then CLEAR_CONFIG with a long sweep
    sd_mode = 0;
    do_step(8'd5);
    exp_time = '0;
    push_exp(exp_time, 1'b0);
    p0 = npulse;
    send(2'd2, 8'd0);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!(clear_act && clear_config && !next_step && !cmd_rdy)) n++;
    end
    chk("clear_hold_bad_cycles", 32'(n), 0);
    @(posedge clk); #1;
    clear_done = 1'b1;
    wait_clear_drop();
    chk("release_clear_config", 32'(clear_config), 0);
    chk("release_cur_time", 32'(cur_time), 0);
    chk("release_cmd_rdy", 32'(cmd_rdy), 0);
    @(posedge clk); #1;
    clear_done = 1'b0;
    @(negedge clk);
    chk("release_held_rsp_vld", 32'(rsp_vld), 0);
    chk("release_held_cmd_rdy", 32'(cmd_rdy), 0);
    wait_idle(100);
    chk("clear_pulses", 32'(npulse - p0), 0);
    chk("clear_cmd_rdy_back", 32'(cmd_rdy), 1);

    // Wrap of the step counter
    @(negedge clk);
    force dut.cur_time = 16'hFFFF;
    @(negedge clk);
    release dut.cur_time;
    exp_time = 16'hFFFF;
    sd_mode = 1;
    do_step(8'd2);

    // CLEAR_ACT leaves clear_config low
    exp_time = '0;
    push_exp(exp_time, 1'b0);
    send(2'd1, 8'd0);
    @(negedge clk);
    chk("clear_act_only_act", 32'(clear_act), 1);
    chk("clear_act_only_cfg", 32'(clear_config), 0);
    @(posedge clk); #1;
    clear_done = 1'b1;
    wait_clear_drop();
    @(posedge clk); #1;
    clear_done = 1'b0;
    wait_idle(100);

    // Reset in the middle of a clear: outputs drop at once, no response
    send(2'd1, 8'd0);
    repeat (5) @(negedge clk);
    chk("midclear_act", 32'(clear_act), 1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("midclear_reset");
    exp_time = '0;
    release_reset();

`ifdef UCASPIAN_STEP_TIMEOUT_EN
    sd_mode = 1;
    do_step(8'd3);
    sd_mode = 2;
    push_exp(exp_time, 1'b1);
    send(2'd0, 8'd1);
    wait_idle(1300);
    chk("timeout_cur_time", 32'(cur_time), 32'(exp_time));
    send(2'd0, 8'd1);
    repeat (50) @(negedge clk);
    chk("midwait_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("midwait_reset");
    exp_time = '0;
    sd_mode = 1;
    release_reset();
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "bench did not finish");
  end

endmodule
